// File: rtl/memory_rc.sv
// memory_rc: parametrised word-addressed single-port synchronous SRAM model
// for the MBIST flow. Linear address is {RA,CA}. After reset, and on
// init_req, a sequential sweep writes INIT_VAL to every word while
// init_busy is high. Reads are registered and take one clock; rvalid
// strobes alongside each update of dataout. When read and write hit the
// same word in one cycle, the read returns the old contents.
//
// Optional feature, enabled by defining MEMORY_RC_FAULT_INJ_EN: adds the
// fi_* ports. While fi_en=1, bit fi_bit of word fi_addr is stuck at fi_val
// for writes, init-sweep writes and reads.
module memory_rc #(
  parameter int                DWIDTH   = 8,
  parameter int                RAWIDTH  = 2,
  parameter int                CAWIDTH  = 4,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RAWIDTH-1:0]         RA,
  input  logic [CAWIDTH-1:0]         CA,
  input  logic                       we,
  input  logic [DWIDTH-1:0]          datain,
  input  logic                       re,
  input  logic                       init_req,
`ifdef MEMORY_RC_FAULT_INJ_EN
  input  logic                       fi_en,
  input  logic [RAWIDTH+CAWIDTH-1:0] fi_addr,
  input  logic [$clog2(DWIDTH)-1:0]  fi_bit,
  input  logic                       fi_val,
`endif
  output logic [DWIDTH-1:0]          dataout,
  output logic                       rvalid,
  output logic                       init_busy
);

  localparam int AWIDTH = RAWIDTH + CAWIDTH;
  localparam int DEPTH  = 2 ** AWIDTH;

  // One extra counter bit so the terminal compare never aliases a wrap.
  localparam logic [AWIDTH:0] LAST_ADDR = (AWIDTH + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [AWIDTH:0]     sweep_cnt, sweep_cnt_nxt;
  logic [AWIDTH-1:0]   addr;
  logic                mem_we;
  logic [AWIDTH-1:0]   mem_waddr;
  logic [DWIDTH-1:0]   mem_wdata;
  logic [DWIDTH-1:0]   mem_wdata_eff;
  logic                rd_en;
  logic [DWIDTH-1:0]   rd_word;

  logic [DWIDTH-1:0]   mem [DEPTH];

  assign addr      = {RA, CA};
  assign init_busy = (state == ST_INIT);

  // State and sweep-counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  // Next-state logic plus array write/read control.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    mem_we        = 1'b0;
    mem_waddr     = addr;
    mem_wdata     = datain;
    rd_en         = 1'b0;
    unique case (state)
      ST_INIT: begin
        mem_we        = 1'b1;
        mem_waddr     = sweep_cnt[AWIDTH-1:0];
        mem_wdata     = INIT_VAL;
        sweep_cnt_nxt = sweep_cnt + (AWIDTH + 1)'(1);
        if (sweep_cnt == LAST_ADDR) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (init_req) begin
          state_nxt     = ST_INIT;
          sweep_cnt_nxt = '0;
        end else begin
          mem_we = we;
          rd_en  = re;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

`ifdef MEMORY_RC_FAULT_INJ_EN
  logic [DWIDTH-1:0] fi_mask;
  logic [DWIDTH-1:0] fi_force;

  // Stuck-at overlay applied to both the write path and the read path.
  always_comb begin
    fi_mask  = fi_en ? (DWIDTH'(1) << fi_bit) : '0;
    fi_force = fi_val ? fi_mask : '0;
    mem_wdata_eff = mem_wdata;
    rd_word       = mem[addr];
    if (mem_waddr == fi_addr) begin
      mem_wdata_eff = (mem_wdata & ~fi_mask) | fi_force;
    end
    if (addr == fi_addr) begin
      rd_word = (mem[addr] & ~fi_mask) | fi_force;
    end
  end
`else
  assign mem_wdata_eff = mem_wdata;
  assign rd_word       = mem[addr];
`endif

  // Array write port; the reset cycle leaves contents untouched.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term; the init sweep defines its contents, which keeps it mappable to a RAM macro.
    if (rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata_eff;
    end
  end

  // Registered read data and its valid strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dataout <= '0;
      rvalid  <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        // NOTE: non-blocking assignments on both ports make a same-address read see the pre-write word.
        dataout <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_memory_rc.sv
// Directed self-checking bench for memory_rc (default parameters: 8-bit
// words, 64 addresses, INIT_VAL = 0). Fault-injection vectors run when
// MEMORY_RC_FAULT_INJ_EN is defined.
module tb_memory_rc;

  logic       clk;
  logic       rst;
  logic [1:0] RA;
  logic [3:0] CA;
  logic       we;
  logic [7:0] datain;
  logic       re;
  logic       init_req;
  logic [7:0] dataout;
  logic       rvalid;
  logic       init_busy;
`ifdef MEMORY_RC_FAULT_INJ_EN
  logic       fi_en;
  logic [5:0] fi_addr;
  logic [2:0] fi_bit;
  logic       fi_val;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  memory_rc dut (
    .clk       (clk),
    .rst       (rst),
    .RA        (RA),
    .CA        (CA),
    .we        (we),
    .datain    (datain),
    .re        (re),
    .init_req  (init_req),
`ifdef MEMORY_RC_FAULT_INJ_EN
    .fi_en     (fi_en),
    .fi_addr   (fi_addr),
    .fi_bit    (fi_bit),
    .fi_val    (fi_val),
`endif
    .dataout   (dataout),
    .rvalid    (rvalid),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and samples change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    RA = a[5:4]; CA = a[3:0]; datain = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
    RA = a[5:4]; CA = a[3:0]; re = 1'b1;
    step();
    re = 1'b0;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_data"}, 32'(dataout), 32'(exp));
  endtask

  // Count cycles until init_busy drops, holding re/we high to show they are
  // ignored during the sweep. Bounded so a stuck sweep still reaches the end.
  task automatic count_busy(input string tag);
    int n;
    int strobes;
    n = 0;
    strobes = 0;
    re = 1'b1; we = 1'b1; datain = 8'hEE;
    while (n < 200) begin
      step();
      n++;
      if (rvalid) strobes++;
      if (!init_busy) break;
    end
    re = 1'b0; we = 1'b0;
    check({tag, "_busy_cycles"}, 32'(n), 32'd64);
    check({tag, "_no_rvalid"}, 32'(strobes), 32'd0);
  endtask

  task automatic read_all(input string tag, input logic [7:0] exp);
    int bad;
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      RA = 2'(a >> 4); CA = 4'(a); re = 1'b1;
      step();
      if (!rvalid || dataout !== exp) bad++;
    end
    re = 1'b0;
    check({tag, "_words_wrong"}, 32'(bad), 32'd0);
  endtask

  initial begin
    rst = 1'b0; RA = '0; CA = '0; we = 1'b0; datain = '0; re = 1'b0; init_req = 1'b0;
`ifdef MEMORY_RC_FAULT_INJ_EN
    fi_en = 1'b0; fi_addr = '0; fi_bit = '0; fi_val = 1'b0;
`endif

    // Reset: one clock low.
    step();
    check("rst_busy", 32'(init_busy), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);
    rst = 1'b1;
    count_busy("boot");
    read_all("boot", 8'h00);

    // Write then read at RA=2,CA=9; then an idle cycle.
    wr({2'd2, 4'd9}, 8'hA5);
    rd("wr_rd", {2'd2, 4'd9}, 8'hA5);
    step();
    check("idle_rvalid", 32'(rvalid), 32'd0);
    check("idle_hold", 32'(dataout), 32'hA5);

    // Read-first collision at {1,3}.
    wr({2'd1, 4'd3}, 8'h3C);
    RA = 2'd1; CA = 4'd3; datain = 8'hFF; we = 1'b1; re = 1'b1;
    step();
    we = 1'b0; re = 1'b0;
    check("coll_rvalid", 32'(rvalid), 32'd1);
    check("coll_old", 32'(dataout), 32'h3C);
    rd("coll_new", {2'd1, 4'd3}, 8'hFF);

    // Re-init: fill with 0x55, then init_req together with a write.
    for (int a = 0; a < 64; a++) wr(6'(a), 8'h55);
    rd("fill", 6'd17, 8'h55);
    RA = '0; CA = '0; datain = 8'h99; we = 1'b1; re = 1'b1; init_req = 1'b1;
    step();
    we = 1'b0; re = 1'b0; init_req = 1'b0;
    check("reinit_busy", 32'(init_busy), 32'd1);
    check("reinit_rvalid", 32'(rvalid), 32'd0);
    check("reinit_hold", 32'(dataout), 32'h55);
    count_busy("reinit");
    read_all("reinit", 8'h00);

    // Reset mid-sweep at sweep address 20.
    wr(6'd0, 8'h77);
    wr(6'd63, 8'h77);
    rd("pre_rst", 6'd63, 8'h77);
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    repeat (20) step();
    check("mid_busy", 32'(init_busy), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_busy", 32'(init_busy), 32'd1);
    check("mid_rst_dataout", 32'(dataout), 32'd0);
    count_busy("restart");
    rd("restart_a0", 6'd0, 8'h00);
    rd("restart_a63", 6'd63, 8'h00);

`ifdef MEMORY_RC_FAULT_INJ_EN
    fi_en = 1'b1; fi_addr = 6'd5; fi_bit = 3'd0; fi_val = 1'b1;
    wr(6'd5, 8'h00);
    rd("fi_stuck", 6'd5, 8'h01);
    rd("fi_neigh", 6'd6, 8'h00);
    fi_en = 1'b0;
    rd("fi_stored", 6'd5, 8'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
